// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALTED
  } fetch_state_t;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count; holds PC tags and buffered instructions.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front-end: owns the PC, issues word fetches, buffers returns for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect raises sticky fetch_error and halts.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter int                   DEPTH     = 2,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] inst_pc,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 halted,
  output logic                 fetch_error
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a cycle where valid && ready; the sender holds
  // its payload stable while valid && !ready. Memory responses are in-order and unthrottled.

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [WORD_SIZE-1:0]   pc;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       occupancy;
  logic [CNT_W-1:0]       discard;
  logic [CNT_W:0]         in_flight;
  logic                   req_fire;
  logic                   resp_keep;
  logic                   inst_fire;
  logic                   misaligned;
  logic [WORD_SIZE-1:0]   tag_head;
  logic [2*WORD_SIZE-1:0] buf_head;

  assign in_flight  = {1'b0, outstanding} + {1'b0, occupancy};
  assign req_fire   = imem_req_valid && imem_req_ready;
  assign inst_fire  = inst_valid && inst_ready;
  assign resp_keep  = imem_resp_valid && (discard == '0) && !redirect_valid && (state != HALTED);
  assign imem_req_addr = pc;
  assign instruction   = buf_head[2*WORD_SIZE-1:WORD_SIZE];
  assign inst_pc       = buf_head[WORD_SIZE-1:0];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) fetch_error <= 1'b0;
    else if (misaligned) fetch_error <= 1'b1;
  end
`else
  assign misaligned  = 1'b0;
  assign fetch_error = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    halted         = 1'b0;
    unique case (state)
      BOOT:    state_next = FETCH;
      FETCH: begin
        if (halt) state_next = HALTED;
        imem_req_valid = !redirect_valid && (in_flight < (CNT_W+1)'(DEPTH));
      end
      HALTED:  halted = 1'b1;
      default: state_next = BOOT;
    endcase
    if (misaligned) state_next = HALTED;
    inst_valid = (occupancy != '0) && !redirect_valid && (state != HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      discard <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        if (!misaligned) pc <= redirect_pc & ~WORD_SIZE'(3);
        // Everything still in flight belongs to the squashed path, minus this cycle's arrival.
        discard <= outstanding - CNT_W'(imem_resp_valid);
      end else begin
        if (req_fire) pc <= pc + WORD_SIZE'(PC_INC);
        if (imem_resp_valid && (discard != '0)) discard <= discard - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_resp_valid),
    .pop_data  (tag_head),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH (2*WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (resp_keep),
    .push_data ({imem_resp_data, tag_head}),
    .pop       (inst_fire),
    .pop_data  (buf_head),
    .count     (occupancy)
  );

  a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
    outstanding <= CNT_W'(DEPTH));
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against a path/epoch reference model.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int          W        = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [W-1:0]  imem_req_addr;
  logic          imem_resp_valid;
  logic [W-1:0]  imem_resp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [W-1:0]  instruction;
  logic [W-1:0]  inst_pc;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          halt;
  logic          halted;
  logic          fetch_error;

  always #5 clk = ~clk;

  instruction_fetch #(
    .WORD_SIZE (W),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .halted          (halted),
    .fetch_error     (fetch_error)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          epoch;
  } mem_req_t;

  // Memory model and reference state.
  mem_req_t     mem_q[$];
  fetch_entry_t exp_q[$];
  logic [W-1:0] acc_addr_log[$];
  int           acc_cyc_log[$];
  int           valid_cyc_log[$];
  logic [W-1:0] pop_pc_log[$];

  int           cyc;
  int           epoch;
  int           buf_n;
  bit           boot_m;
  bit           halted_m;
  logic [W-1:0] exp_req_pc;
  logic [W-1:0] exp_inst_pc;
  int           lat_min;
  int           lat_max;
  int           last_due;
  bit           last_iv;
  bit           last_resp;
  int           n_cmp;
  int           n_fail;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit misaligned_redirect(input logic [W-1:0] target);
`ifdef FETCH_MISALIGN_CHECK_EN
    return target[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    halt            = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    mem_q.delete();
    exp_q.delete();
    buf_n       = 0;
    boot_m      = 1'b1;
    halted_m    = 1'b0;
    exp_req_pc  = RESET_PC;
    exp_inst_pc = RESET_PC;
    last_due    = cyc;
    reset       = 1'b0;
  endtask

  // One clock: drive memory, observe outputs at mid-cycle, advance the model.
  task automatic step();
    int          outst;
    int          due;
    bit          exp_req;
    bit          exp_iv;
    bit          fresh;
    bit          push_m;
    bit          pop_m;
    bit          halted_next;
    mem_req_t    head;
    fetch_entry_t ent;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    fresh           = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      head            = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(head.addr);
      fresh           = (head.epoch == epoch);
    end
    #1;
    outst   = mem_q.size() + (imem_resp_valid ? 1 : 0);
    exp_req = !boot_m && !halted_m && !redirect_valid && (outst + buf_n < DEPTH);
    exp_iv  = (buf_n > 0) && !redirect_valid && !halted_m;
    last_iv   = inst_valid;
    last_resp = imem_resp_valid;
    n_cmp++;
    if (imem_req_valid !== exp_req) begin
      n_fail++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
    end
    n_cmp++;
    if (inst_valid !== exp_iv) begin
      n_fail++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_iv);
    end
    if (imem_req_valid && imem_req_ready) begin
      n_cmp++;
      if (imem_req_addr !== exp_req_pc) begin
        n_fail++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_pc);
      end
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{due: due, addr: imem_req_addr, epoch: epoch});
      acc_addr_log.push_back(imem_req_addr);
      acc_cyc_log.push_back(cyc);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (inst_valid) valid_cyc_log.push_back(cyc);
    if (inst_valid && inst_ready) begin
      ent.pc    = exp_inst_pc;
      ent.instr = mem_word(exp_inst_pc);
      exp_q.push_back(ent);
      ent = exp_q.pop_front();
      n_cmp++;
      if (inst_pc !== ent.pc) begin
        n_fail++;
        $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, ent.pc);
      end
      n_cmp++;
      if (instruction !== ent.instr) begin
        n_fail++;
        $display("FAIL instruction cyc=%0d got=%h exp=%h", cyc, instruction, ent.instr);
      end
      pop_pc_log.push_back(inst_pc);
      exp_inst_pc = exp_inst_pc + 32'd4;
    end
    push_m      = imem_resp_valid && fresh && !redirect_valid && !halted_m;
    pop_m       = exp_iv && inst_ready;
    halted_next = halted_m || (!boot_m && halt);
    if (redirect_valid) begin
      buf_n = 0;
      epoch++;
      if (misaligned_redirect(redirect_pc)) begin
        halted_next = 1'b1;
      end else begin
        exp_req_pc  = redirect_pc & ~32'd3;
        exp_inst_pc = redirect_pc & ~32'd3;
      end
    end else begin
      buf_n = buf_n + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
    halted_m = halted_next;
    boot_m   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
    end
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_inst_valid got=%b exp=0", inst_valid);
    end
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_halted got=%b exp=0", halted);
    end
    n_cmp++;
    if (fetch_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fetch_error got=%b exp=0", fetch_error);
    end
    n_cmp++;
    if (imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_pc got=%h exp=%h", imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    lat_min = 1;
    lat_max = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    acc_addr_log.delete();
    acc_cyc_log.delete();
    valid_cyc_log.delete();
    pop_pc_log.delete();
    repeat (12) step();
    n_cmp++;
    if (acc_addr_log.size() < 3 || valid_cyc_log.size() < 1 || pop_pc_log.size() < 1) begin
      n_fail++;
      $display("FAIL stream_activity accepts=%0d valids=%0d pops=%0d exp=>=3/>=1/>=1",
               acc_addr_log.size(), valid_cyc_log.size(), pop_pc_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (acc_addr_log[i] !== 32'(4 * i)) begin
          n_fail++;
          $display("FAIL stream_addr%0d got=%h exp=%h", i, acc_addr_log[i], 32'(4 * i));
        end
      end
      n_cmp++;
      if (acc_cyc_log[1] !== acc_cyc_log[0] + 1) begin
        n_fail++;
        $display("FAIL stream_b2b got=%0d exp=%0d", acc_cyc_log[1], acc_cyc_log[0] + 1);
      end
      n_cmp++;
      if (valid_cyc_log[0] !== acc_cyc_log[0] + 2) begin
        n_fail++;
        $display("FAIL stream_latency got=%0d exp=%0d", valid_cyc_log[0], acc_cyc_log[0] + 2);
      end
      n_cmp++;
      if (pop_pc_log[0] !== RESET_PC) begin
        n_fail++;
        $display("FAIL stream_first_pc got=%h exp=%h", pop_pc_log[0], RESET_PC);
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    repeat (10) step();
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_req_valid got=%b exp=0", imem_req_valid);
    end
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_inst_valid got=%b exp=1", inst_valid);
    end
    inst_ready = 1'b1;
    pop_pc_log.delete();
    repeat (10) step();
    n_cmp++;
    if (pop_pc_log.size() < 3) begin
      n_fail++;
      $display("FAIL bp_drain pops=%0d exp=>=3", pop_pc_log.size());
    end
  endtask

  task automatic test_redirect();
    bit found;
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_q.size() == DEPTH) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL redirect_setup outstanding=%0d exp=%0d", mem_q.size(), DEPTH);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    lat_min = 1;
    lat_max = 1;
    pop_pc_log.delete();
    repeat (14) step();
    n_cmp++;
    if (pop_pc_log.size() < 2) begin
      n_fail++;
      $display("FAIL redirect_pops got=%0d exp=>=2", pop_pc_log.size());
    end else begin
      n_cmp++;
      if (pop_pc_log[0] !== 32'h100) begin
        n_fail++;
        $display("FAIL redirect_pc0 got=%h exp=00000100", pop_pc_log[0]);
      end
      n_cmp++;
      if (pop_pc_log[1] !== 32'h104) begin
        n_fail++;
        $display("FAIL redirect_pc1 got=%h exp=00000104", pop_pc_log[1]);
      end
    end
  endtask

  task automatic test_redirect_with_resp();
    bit found;
    inst_ready = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (buf_n > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL rr_setup buffered=%0d pending=%0d exp=>0/>0", buf_n, mem_q.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (last_iv !== 1'b0 || last_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_same_cycle inst_valid=%b resp=%b exp=0/1", last_iv, last_resp);
    end
    pop_pc_log.delete();
    repeat (10) step();
    n_cmp++;
    if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL rr_restart pops=%0d first=%h exp=00000200",
               pop_pc_log.size(), (pop_pc_log.size() > 0) ? pop_pc_log[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    int pops_before;
    pops_before = pop_pc_log.size();
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom() & 32'h0000_FFFC;
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (8) step();
    n_cmp++;
    if (pop_pc_log.size() <= pops_before + 20) begin
      n_fail++;
      $display("FAIL random_progress pops=%0d exp=>%0d", pop_pc_log.size(), pops_before + 20);
    end
  endtask

  task automatic test_misalign();
    lat_min = 1;
    lat_max = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    pop_pc_log.delete();
    repeat (10) step();
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++;
    if (fetch_error !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_error got=%b exp=1", fetch_error);
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_halted got=%b exp=1", halted);
    end
`else
    n_cmp++;
    if (fetch_error !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_error got=%b exp=0", fetch_error);
    end
    n_cmp++;
    if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL misalign_resume pops=%0d first=%h exp=00000100",
               pop_pc_log.size(), (pop_pc_log.size() > 0) ? pop_pc_log[0] : 32'hx);
    end
`endif
  endtask

  task automatic test_halt();
    bit found;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    found          = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!boot_m && mem_q.size() > 0) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL halt_setup pending=%0d exp=>0", mem_q.size());
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    repeat (8) step();
    #1;
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_halted got=%b exp=1", halted);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_quiet req_valid=%b inst_valid=%b exp=0/0", imem_req_valid, inst_valid);
    end
    // Redirect and halt together: PC moves to the target, then the unit halts.
    do_reset();
    lat_min = 1;
    lat_max = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    halt           = 1'b1;
    step();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    repeat (3) step();
    #1;
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_halt_halted got=%b exp=1", halted);
    end
    n_cmp++;
    if (imem_req_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL redir_halt_pc got=%h exp=00000300", imem_req_addr);
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    cyc             = 0;
    epoch           = 0;
    lat_min         = 1;
    lat_max         = 1;
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    halt            = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_with_resp();
    test_random();
    test_misalign();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
